// File: rtl/receptor_param.sv
// Parameterised asynchronous serial receiver: start-bit validation at half bit,
// centre sampling of data/parity/stop bits, overrun and framing/parity status.
module receptor_param #(
  parameter int CLKS_PER_BIT = 459,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 deteccion_flanco_bajada,
  input  logic                 x,
  input  logic                 dato_leido,
  output logic [DATA_BITS-1:0] dato,
  output logic                 dato_listo,
  output logic                 error_paridad,
  output logic                 error_trama,
  output logic                 sobrescritura,
  output logic                 ocupado
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]  LAST_DB  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_SB  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {REPOSO, INICIO, DATOS, PARIDAD, PARADA, ESPERA} state_t;

  state_t               state_q, state_d;
  logic                 sync_a_q, sync_a_d;
  logic                 xs_q, xs_d;
  logic                 xs_prev_q, xs_prev_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] dato_q, dato_d;
  logic                 listo_q, listo_d;
  logic                 ep_q, ep_d;
  logic                 et_q, et_d;
  logic                 sob_q, sob_d;
  logic                 complete;
  logic                 frame_err;
  logic                 tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= REPOSO;
      sync_a_q  <= 1'b1;
      xs_q      <= 1'b1;
      xs_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      dato_q    <= '0;
      listo_q   <= 1'b0;
      ep_q      <= 1'b0;
      et_q      <= 1'b0;
      sob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_a_q  <= sync_a_d;
      xs_q      <= xs_d;
      xs_prev_q <= xs_prev_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      dato_q    <= dato_d;
      listo_q   <= listo_d;
      ep_q      <= ep_d;
      et_q      <= et_d;
      sob_q     <= sob_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sync_a_d  = x;
    xs_d      = sync_a_q;
    xs_prev_d = xs_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    dato_d    = dato_q;
    listo_d   = listo_q;
    ep_d      = ep_q;
    et_d      = et_q;
    sob_d     = sob_q;
    complete  = 1'b0;
    frame_err = 1'b0;
    tick      = (cnt_q == LAST_CNT);

    case (state_q)
      REPOSO: begin
        cnt_d = '0;
        if (deteccion_flanco_bajada && xs_prev_q && !xs_q) state_d = INICIO;
      end
      INICIO: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = xs_q ? REPOSO : DATOS;
        end
      end
      DATOS: begin
        cnt_d = cnt_q + 16'd1;
        if (tick) begin
          cnt_d  = '0;
          sh_d   = {xs_q, sh_q[DATA_BITS-1:1]};
          bit_d  = bit_q + 4'd1;
          perr_d = 1'b0;
          ferr_d = 1'b0;
          if (bit_q == LAST_DB) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PARIDAD : PARADA;
          end
        end
      end
      PARIDAD: begin
        cnt_d = cnt_q + 16'd1;
        if (tick) begin
          cnt_d   = '0;
          state_d = PARADA;
          perr_d  = (PARITY == 1) ? (^sh_q ^ xs_q) : ~(^sh_q ^ xs_q);
        end
      end
      PARADA: begin
        cnt_d = cnt_q + 16'd1;
        if (tick) begin
          cnt_d     = '0;
          frame_err = ferr_q | ~xs_q;
          ferr_d    = frame_err;
          bit_d     = bit_q + 4'd1;
          if (bit_q == LAST_SB) begin
            complete = 1'b1;
            bit_d    = '0;
            state_d  = frame_err ? ESPERA : REPOSO;
          end
        end
      end
      ESPERA: begin
        // A line held low after a bad stop must not be seen as a new start.
        if (xs_q) state_d = REPOSO;
      end
      default: state_d = REPOSO;
    endcase

    // A completion load takes priority over a simultaneous acknowledge.
    if (complete) begin
      dato_d  = sh_q;
      ep_d    = perr_q;
      et_d    = frame_err;
      listo_d = 1'b1;
      sob_d   = listo_q & ~dato_leido;
    end else if (dato_leido) begin
      listo_d = 1'b0;
      sob_d   = 1'b0;
    end
  end

  assign dato          = dato_q;
  assign dato_listo    = listo_q;
  assign error_paridad = ep_q;
  assign error_trama   = et_q;
  assign sobrescritura = sob_q;
  assign ocupado       = (state_q != REPOSO);

endmodule

// File: tb/tb_receptor_param.sv
// Scoreboard bench for receptor_param: an 8N1 instance and an 8E2 instance
// driven by randomized frames, checked against a frame-level reference model.
module tb_receptor_param;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  logic       det0 = 1'b1, x0 = 1'b1, leido0 = 1'b0;
  logic [7:0] dato0;
  logic       listo0, ep0, et0, sob0, ocu0;
  logic       det1 = 1'b1, x1 = 1'b1, leido1 = 1'b0;
  logic [7:0] dato1;
  logic       listo1, ep1, et1, sob1, ocu1;

  receptor_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .deteccion_flanco_bajada(det0), .x(x0), .dato_leido(leido0),
    .dato(dato0), .dato_listo(listo0), .error_paridad(ep0), .error_trama(et0),
    .sobrescritura(sob0), .ocupado(ocu0));

  receptor_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .deteccion_flanco_bajada(det1), .x(x1), .dato_leido(leido1),
    .dato(dato1), .dato_listo(listo1), .error_paridad(ep1), .error_trama(et1),
    .sobrescritura(sob1), .ocupado(ocu1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         perr;
    bit         ferr;
    bit         sob;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   m_listo [2] = '{0, 0};
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: a load is visible as dato_listo rising, dato changing while
  // listo, or sobrescritura rising; each one pops the next expected frame.
  logic       prev_l [2] = '{0, 0};
  logic       prev_s [2] = '{0, 0};
  logic [7:0] prev_d [2] = '{8'h00, 8'h00};

  task automatic mon(input int ch, input logic [7:0] d, input logic l, input logic ep,
                     input logic et, input logic s);
    exp_t e;
    bit   have;
    if (reset && ((l && !prev_l[ch]) || (l && d !== prev_d[ch]) || (s && !prev_s[ch]))) begin
      have = 1'b0;
      if (ch == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (ch == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        n_tests++;
        n_fail++;
        $display("FAIL ch%0d unexpected load: dato=%0h", ch, d);
      end else begin
        $display("[TB] ch%0d load dato=%0h perr=%0b ferr=%0b sob=%0b cyc=%0d", ch, d, ep, et, s, cyc);
        chk($sformatf("ch%0d dato", ch), 32'(d), 32'(e.data));
        chk($sformatf("ch%0d listo", ch), 32'(l), 32'd1);
        chk($sformatf("ch%0d error_paridad", ch), 32'(ep), 32'(e.perr));
        chk($sformatf("ch%0d error_trama", ch), 32'(et), 32'(e.ferr));
        chk($sformatf("ch%0d sobrescritura", ch), 32'(s), 32'(e.sob));
        chk($sformatf("ch%0d load cycle", ch), 32'(cyc), 32'(e.cyc));
      end
    end
    prev_l[ch] = l;
    prev_s[ch] = s;
    prev_d[ch] = d;
  endtask

  always @(negedge clk) begin
    mon(0, dato0, listo0, ep0, et0, sob0);
    mon(1, dato1, listo1, ep1, et1, sob1);
  end

  task automatic setx(input int ch, input logic v);
    if (ch == 0) x0 = v; else x1 = v;
  endtask

  task automatic setl(input int ch, input logic v);
    if (ch == 0) leido0 = v; else leido1 = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " dato0"}, 32'(dato0), 0);
    chk({tag, " listo0"}, 32'(listo0), 0);
    chk({tag, " err0"}, 32'({ep0, et0, sob0}), 0);
    chk({tag, " ocupado0"}, 32'(ocu0), 0);
    chk({tag, " dato1"}, 32'(dato1), 0);
    chk({tag, " listo1"}, 32'(listo1), 0);
    chk({tag, " err1"}, 32'({ep1, et1, sob1}), 0);
    chk({tag, " ocupado1"}, 32'(ocu1), 0);
  endtask

  // Drives one frame. ch0 is 8N1, ch1 is 8E2. Expected status comes from the
  // frame contents: parity by popcount, framing by any low stop bit.
  task automatic send(input int ch, input logic [7:0] data, input bit pbit,
                      input logic [1:0] stops, input bit push, input bit ack_load,
                      input int abort_bit, input int hold);
    logic [15:0] bits;
    int          nb;
    int          nstop;
    exp_t        e;
    bit          aborted;
    nstop = (ch == 0) ? 1 : 2;
    bits  = '0;
    nb    = 1;
    for (int i = 0; i < 8; i++) begin bits[nb] = data[i]; nb++; end
    if (ch == 1) begin bits[nb] = pbit; nb++; end
    for (int s = 0; s < nstop; s++) begin bits[nb] = stops[s]; nb++; end
    e.data = data;
    e.perr = (ch == 1) ? (((($countones(data) + int'(pbit)) % 2) != 0)) : 1'b0;
    e.ferr = (nstop == 1) ? !stops[0] : !(stops[0] && stops[1]);
    e.sob  = m_listo[ch] && !ack_load;
    @(negedge clk);
    e.cyc = cyc + 3 + HALF + (nb - 1) * CPB;
    if (push) begin
      if (ch == 0) q0.push_back(e); else q1.push_back(e);
      m_listo[ch] = 1'b1;
    end
    $display("[TB] ch%0d send data=%0h pbit=%0b stops=%0b push=%0b", ch, data, pbit, stops, push);
    aborted = 1'b0;
    for (int i = 0; i < nb * CPB; i++) begin
      setx(ch, bits[i / CPB]);
      if (ack_load) setl(ch, cyc == e.cyc - 1);
      if (abort_bit >= 0 && i == abort_bit * CPB + HALF) begin
        reset = 1'b0;
        #1;
        chk_all_zero("mid-frame reset");
        m_listo[0] = 1'b0;
        m_listo[1] = 1'b0;
        setx(ch, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    setl(ch, 1'b0);
    if (hold > 0 && !aborted) begin
      setx(ch, 1'b0);
      repeat (hold) @(negedge clk);
      chk($sformatf("ch%0d ocupado while held low", ch), 32'((ch == 0) ? ocu0 : ocu1), 32'd1);
    end
    setx(ch, 1'b1);
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic ack(input int ch);
    @(negedge clk);
    setl(ch, 1'b1);
    @(negedge clk);
    setl(ch, 1'b0);
    m_listo[ch] = 1'b0;
    chk($sformatf("ch%0d listo after ack", ch), 32'((ch == 0) ? listo0 : listo1), 32'd0);
    chk($sformatf("ch%0d sob after ack", ch), 32'((ch == 0) ? sob0 : sob1), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    bit         pb;
    logic [1:0] st;

    #5;
    chk_all_zero("in reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("after release");

    // 8N1 directed frame, then acknowledge.
    send(0, 8'hA5, 1'b0, 2'b11, 1'b1, 1'b0, -1, 0);
    ack(0);

    // Even parity: wrong then correct parity bit.
    send(1, 8'h07, 1'b0, 2'b11, 1'b1, 1'b0, -1, 0);
    ack(1);
    send(1, 8'h07, 1'b1, 2'b11, 1'b1, 1'b0, -1, 0);
    ack(1);

    // Randomized frames on both channels.
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      send(0, d, 1'b0, 2'b11, 1'b1, 1'b0, -1, 0);
      ack(0);
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send(1, d, pb, st, 1'b1, 1'b0, -1, 0);
      ack(1);
    end

    // Bad stop bit with the line held low for three bit times.
    send(0, 8'hC3, 1'b0, 2'b00, 1'b1, 1'b0, -1, 3 * CPB);
    repeat (5) @(negedge clk);
    chk("ch0 ocupado after line release", 32'(ocu0), 32'd0);
    ack(0);
    send(0, 8'h3C, 1'b0, 2'b11, 1'b1, 1'b0, -1, 0);
    ack(0);

    // False start: short low pulse.
    @(negedge clk);
    x0 = 1'b0;
    repeat (3) @(negedge clk);
    x0 = 1'b1;
    chk("false start ocupado high", 32'(ocu0), 32'd1);
    repeat (HALF + 4) @(negedge clk);
    chk("false start ocupado back low", 32'(ocu0), 32'd0);
    chk("false start listo", 32'(listo0), 32'd0);

    // Edge detection disabled: a full frame is ignored.
    det0 = 1'b0;
    send(0, 8'h96, 1'b0, 2'b11, 1'b0, 1'b0, -1, 0);
    chk("detection off listo", 32'(listo0), 32'd0);
    chk("detection off ocupado", 32'(ocu0), 32'd0);
    det0 = 1'b1;

    // Dropping detection mid-frame must not abort the frame.
    fork
      send(1, 8'h5C, 1'b0, 2'b11, 1'b1, 1'b0, -1, 0);
      begin
        repeat (3 * CPB) @(negedge clk);
        det1 = 1'b0;
      end
    join
    det1 = 1'b1;
    ack(1);

    // Overrun, then acknowledge colliding with a completion load.
    send(0, 8'h11, 1'b0, 2'b11, 1'b1, 1'b0, -1, 0);
    send(0, 8'h22, 1'b0, 2'b11, 1'b1, 1'b0, -1, 0);
    ack(0);
    send(0, 8'h11, 1'b0, 2'b11, 1'b1, 1'b0, -1, 0);
    send(0, 8'h22, 1'b0, 2'b11, 1'b1, 1'b1, -1, 0);
    chk("collision listo stays", 32'(listo0), 32'd1);
    ack(0);

    // Reset during data bit 4, then a clean frame.
    send(0, 8'hFF, 1'b0, 2'b11, 1'b0, 1'b0, 5, 0);
    send(0, 8'h5A, 1'b0, 2'b11, 1'b1, 1'b0, -1, 0);
    ack(0);

    repeat (4) @(negedge clk);
    chk("ch0 all expected loads seen", 32'(q0.size()), 32'd0);
    chk("ch1 all expected loads seen", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/receptor_param.md
RECEPTOR_PARAM -- requirements
Module: receptor_param

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 459, clock cycles per serial bit; legal range 4..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1, 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port deteccion_flanco_bajada, input, 1 bit: when 1, a falling edge on x may start a frame.
REQ-008 The block SHALL have port x, input, 1 bit: asynchronous serial line, idle high, LSB first.
REQ-009 The block SHALL have port dato_leido, input, 1 bit: consumer acknowledge that clears dato_listo.
REQ-010 The block SHALL have port dato, output, DATA_BITS bits: last received data word.
REQ-011 The block SHALL have port dato_listo, output, 1 bit: high while dato holds an unread word.
REQ-012 The block SHALL have ports error_paridad, error_trama and sobrescritura, outputs, 1 bit each: status of the last completed frame.
REQ-013 The block SHALL have port ocupado, output, 1 bit: high in any state except REPOSO.

Function
REQ-014 x SHALL pass through a 2-flop synchroniser (flops reset to 1); all sampling and edge detection SHALL use the synchronised value xs and its 1-cycle delay xs_d.
REQ-015 States SHALL be REPOSO, INICIO, DATOS, PARIDAD, PARADA and ESPERA; counter cnt SHALL be 16 bits; HALF = CLKS_PER_BIT/2, truncated.
REQ-016 REPOSO: if deteccion_flanco_bajada=1, xs_d=1 and xs=0, go to INICIO with cnt=0.
REQ-017 INICIO: cnt increments each cycle; at cnt=HALF-1, if xs=0 go to DATOS with cnt=0, else go to REPOSO as a false start with no outputs changed.
REQ-018 DATOS, PARIDAD and PARADA: sample xs when cnt=CLKS_PER_BIT-1, then reset cnt to 0; each sample is therefore at bit centre.
REQ-019 DATOS: shift in DATA_BITS samples, LSB first; then go to PARIDAD if PARITY!=0, else to PARADA.
REQ-020 PARIDAD: one sample; parity error = (XOR of data bits XOR sample) != 0 for even, == 0 for odd.
REQ-021 PARADA: STOP_BITS samples; a 0 in any of them is a framing error.
REQ-022 Completion occurs on the cycle of the final stop sample; in the next cycle dato, error_paridad and error_trama SHALL be loaded and dato_listo SHALL be set to 1.
REQ-023 After completion the block SHALL go to REPOSO if the frame had no framing error, else to ESPERA.
REQ-024 ESPERA: hold until xs=1 (break or stuck-low line), then go to REPOSO; no start is detected while in ESPERA.
REQ-025 sobrescritura SHALL be set to 1 when a frame completes while dato_listo=1 and dato_leido=0; dato is overwritten with the new word.
REQ-026 sobrescritura SHALL clear only with dato_listo, or on reset.
REQ-027 dato_leido=1 SHALL clear dato_listo and sobrescritura in the next cycle, unless a completion load occurs in that same cycle; a completion load wins, setting dato_listo=1 with sobrescritura=0.
REQ-028 Deasserting deteccion_flanco_bajada mid-frame SHALL NOT abort the frame; it gates only the REPOSO to INICIO transition.
REQ-029 Frame latency SHALL be fixed: the final stop sample occurs HALF + (DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles after INICIO entry.

Reset
REQ-030 reset=0 SHALL immediately force: state REPOSO, cnt=0, synchroniser flops=1, shift register=0, dato=0, dato_listo=0, error_paridad=0, error_trama=0, sobrescritura=0, ocupado=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait for a new falling edge in REPOSO.

Verification
REQ-032 Defaults, 20 ns clk, bit time 9180 ns, frame 0xA5 8N1 -> dato=0xA5, dato_listo=1, all errors 0, 1 cycle after mid-stop; dato_leido pulse -> dato_listo=0.
REQ-033 PARITY=1, frame 0x07 with parity bit 0 -> dato=0x07, error_paridad=1; repeat with parity bit 1 -> error_paridad=0.
REQ-034 Stop bit 0 and x held low 3 bit times -> error_trama=1, ocupado stays 1 (ESPERA) until x returns high, then the next frame 0x3C is received correctly.
REQ-035 x low for 100 cycles then high -> false start, ocupado returns to 0, dato_listo stays 0; with deteccion_flanco_bajada=0, a full frame -> no reception.
REQ-036 Two frames 0x11 then 0x22 with no dato_leido -> dato=0x22, sobrescritura=1; dato_leido in the same cycle as the second load -> sobrescritura=0, dato_listo=1.
REQ-037 Reset pulsed during data bit 4 -> all outputs 0 immediately; the following full frame 0x5A -> dato=0x5A.
